// File: rtl/anita_phi_trigger_router_pkg.sv
// Map-entry layout shared by the phi-sector trigger router, its interface and its bench.
// Entry = {valid, pol (0=V, 1=H), phi[PHI_W-1:0]}.
package anita_trig_pkg;

  localparam int PHI_W     = 4;
  localparam int MAP_W     = PHI_W + 2;
  localparam int MAP_VALID = MAP_W - 1;
  localparam int MAP_POL   = MAP_W - 2;

  localparam logic POL_V = 1'b0;
  localparam logic POL_H = 1'b1;

  typedef struct packed {
    logic             valid;
    logic             pol;
    logic [PHI_W-1:0] phi;
  } map_entry_t;

  // V lines occupy [0, num_phi), H lines [num_phi, 2*num_phi)
  function automatic int line_index(input map_entry_t e, input int num_phi);
    return (e.pol == POL_V) ? int'(e.phi) : (num_phi + int'(e.phi));
  endfunction

endpackage

// File: rtl/anita_phi_trigger_router_if.sv
// Software map-programming bus of the phi-sector trigger router.
interface anita_phi_trigger_router_if #(
  parameter int ADDR_W = 6
);
  logic                          map_wr;
  logic [ADDR_W-1:0]             map_addr;
  logic [anita_trig_pkg::MAP_W-1:0] map_data;
  logic                          map_commit;
  logic                          map_err;

  modport master (output map_wr, map_addr, map_data, map_commit, input map_err);
  modport slave  (input map_wr, map_addr, map_data, map_commit, output map_err);
endinterface

// File: rtl/anita_phi_trigger_router_stretch.sv
// Per-line output stage: mask kill, retriggerable reload and countdown stretch.
module trig_pulse_stretch #(
  parameter int STRETCH_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 route,
  input  logic                 mask,
  input  logic [STRETCH_W-1:0] stretch_len,
  output logic                 pulse
);

  logic [STRETCH_W-1:0] count_r;
  logic                 pulse_r;

  // Mask wins over a fresh trigger so a masked line can never fire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
      pulse_r <= 1'b0;
    end else if (mask) begin
      count_r <= '0;
      pulse_r <= 1'b0;
    end else if (route) begin
      count_r <= stretch_len;
      pulse_r <= 1'b1;
    end else if (count_r != '0) begin
      count_r <= count_r - STRETCH_W'(1);
      pulse_r <= 1'b1;
    end else begin
      pulse_r <= 1'b0;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/anita_phi_trigger_router.sv
// Programmable SURF L1 -> phi-sector router: shadow/active map, OR routing, mask and stretch.
// Optional per-line rising-edge scalers are built when TRIG_ROUTER_SCALER_EN is defined.
module anita_phi_trigger_router
  import anita_trig_pkg::*;
#(
  parameter int NUM_SURFS = 12,
  parameter int NUM_TRIG  = 4,
  parameter int NUM_PHI   = 16,
`ifdef TRIG_ROUTER_SCALER_EN
  parameter int SCALER_W  = 16,
`endif
  parameter int STRETCH_W = 3,
  localparam int NUM_IN   = NUM_SURFS * NUM_TRIG,
  localparam int ADDR_W   = $clog2(NUM_IN),
  localparam int LINES    = 2 * NUM_PHI,
  localparam int LINE_W   = $clog2(LINES)
) (
  input  logic                     clk250_i,
  input  logic                     rst_n_i,
  input  logic [NUM_IN-1:0]        L1_i,
  input  logic [LINES-1:0]         mask_i,
  input  logic [STRETCH_W-1:0]     stretch_i,
  anita_phi_trigger_router_if.slave map_bus,
`ifdef TRIG_ROUTER_SCALER_EN
  input  logic                     scaler_latch_i,
  input  logic [LINE_W-1:0]        scaler_sel_i,
  output logic [SCALER_W-1:0]      scaler_o,
`endif
  output logic [NUM_PHI-1:0]       V_pol_phi_o,
  output logic [NUM_PHI-1:0]       H_pol_phi_o
);

  logic [NUM_IN-1:0] in_r;
  map_entry_t        shadow_r      [NUM_IN];
  map_entry_t        active_r      [NUM_IN];
  map_entry_t        shadow_next_s [NUM_IN];
  map_entry_t        wr_entry_s;
  logic              addr_ok_s;
  logic              wr_ok_s;
  logic              wr_bad_s;
  logic              map_err_r;
  logic [LINES-1:0]  route_s;
  logic [LINES-1:0]  route_r;
  logic [LINES-1:0]  pulse_s;

  assign addr_ok_s = (int'(map_bus.map_addr) < NUM_IN);
  assign wr_ok_s   = map_bus.map_wr && addr_ok_s;
  assign wr_bad_s  = map_bus.map_wr && !addr_ok_s;

  // Shadow after this edge's write; a same-edge commit copies this, giving write-through
  always_comb begin
    wr_entry_s.valid = map_bus.map_data[MAP_VALID];
    wr_entry_s.pol   = map_bus.map_data[MAP_POL];
    wr_entry_s.phi   = map_bus.map_data[PHI_W-1:0];
    for (int k = 0; k < NUM_IN; k++) begin
      if (wr_ok_s && (int'(map_bus.map_addr) == k)) begin
        shadow_next_s[k] = wr_entry_s;
      end else begin
        shadow_next_s[k] = shadow_r[k];
      end
    end
  end

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NUM_IN; k++) begin
        shadow_r[k] <= '0;
        active_r[k] <= '0;
      end
      map_err_r <= 1'b0;
    end else begin
      shadow_r <= shadow_next_s;
      if (map_bus.map_commit) begin
        active_r <= shadow_next_s;
      end
      if (wr_bad_s) begin
        map_err_r <= 1'b1;
      end else if (map_bus.map_commit) begin
        map_err_r <= 1'b0;
      end
    end
  end

  assign map_bus.map_err = map_err_r;

  // Entries with phi beyond the sector count route nowhere
  always_comb begin
    route_s = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      logic              hit_s;
      logic [LINE_W-1:0] idx_s;
      hit_s = active_r[k].valid && (int'(active_r[k].phi) < NUM_PHI) && in_r[k];
      idx_s = hit_s ? LINE_W'(line_index(active_r[k], NUM_PHI)) : '0;
      route_s[idx_s] = route_s[idx_s] | hit_s;
    end
  end

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      in_r    <= '0;
      route_r <= '0;
    end else begin
      in_r    <= L1_i;
      route_r <= route_s;
    end
  end

  for (genvar i = 0; i < LINES; i++) begin : g_line
    trig_pulse_stretch #(
      .STRETCH_W (STRETCH_W)
    ) u_stretch (
      .clk         (clk250_i),
      .rst_n       (rst_n_i),
      .route       (route_r[i]),
      .mask        (mask_i[i]),
      .stretch_len (stretch_i),
      .pulse       (pulse_s[i])
    );
  end

  assign V_pol_phi_o = pulse_s[NUM_PHI-1:0];
  assign H_pol_phi_o = pulse_s[LINES-1:NUM_PHI];

`ifdef TRIG_ROUTER_SCALER_EN
  localparam logic [SCALER_W-1:0] CNT_MAX = {SCALER_W{1'b1}};

  logic [LINES-1:0]    live_s;
  logic [LINES-1:0]    live_r;
  logic [LINES-1:0]    rise_s;
  logic [SCALER_W-1:0] cnt_r  [LINES];
  logic [SCALER_W-1:0] hold_r [LINES];
  logic [SCALER_W-1:0] scaler_r;

  function automatic logic [SCALER_W-1:0] sat_inc(input logic [SCALER_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) begin
      return v + SCALER_W'(1);
    end else begin
      return v;
    end
  endfunction

  assign live_s = route_r & ~mask_i;
  assign rise_s = live_s & ~live_r;

  // Latch folds in an edge arriving the same cycle so no trigger is lost across the boundary
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      live_r   <= '0;
      scaler_r <= '0;
      for (int i = 0; i < LINES; i++) begin
        cnt_r[i]  <= '0;
        hold_r[i] <= '0;
      end
    end else begin
      live_r   <= live_s;
      scaler_r <= hold_r[scaler_sel_i];
      for (int i = 0; i < LINES; i++) begin
        if (scaler_latch_i) begin
          hold_r[i] <= sat_inc(cnt_r[i], rise_s[i]);
          cnt_r[i]  <= {{(SCALER_W-1){1'b0}}, rise_s[i]};
        end else begin
          cnt_r[i]  <= sat_inc(cnt_r[i], rise_s[i]);
        end
      end
    end
  end

  assign scaler_o = scaler_r;
`endif

endmodule

// File: tb/tb_anita_phi_trigger_router.sv
// Bench for anita_phi_trigger_router: hand vector table, randomized run against a
// timestamp-based reference model, mid-run reset and (with TRIG_ROUTER_SCALER_EN) scalers.
module tb_anita_phi_trigger_router;
  import anita_trig_pkg::*;

  localparam int NI = 48;
  localparam int NP = 16;
  localparam int NL = 32;
`ifdef TRIG_ROUTER_SCALER_EN
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] l1 = '0;
  logic [NL-1:0] mask = '0;
  logic [2:0]    str = '0;
  logic [NP-1:0] vout, hout;
`ifdef TRIG_ROUTER_SCALER_EN
  logic          latch = 1'b0;
  logic [4:0]    sel = '0;
  logic [SW-1:0] scal;
`endif

  anita_phi_trigger_router_if #(.ADDR_W(6)) mbus ();

  anita_phi_trigger_router #(
    .NUM_SURFS (12),
    .NUM_TRIG  (4),
    .NUM_PHI   (NP),
`ifdef TRIG_ROUTER_SCALER_EN
    .SCALER_W  (SW),
`endif
    .STRETCH_W (3)
  ) dut (
    .clk250_i       (clk),
    .rst_n_i        (rst_n),
    .L1_i           (l1),
    .mask_i         (mask),
    .stretch_i      (str),
    .map_bus        (mbus),
`ifdef TRIG_ROUTER_SCALER_EN
    .scaler_latch_i (latch),
    .scaler_sel_i   (sel),
    .scaler_o       (scal),
`endif
    .V_pol_phi_o    (vout),
    .H_pol_phi_o    (hout)
  );

  always #2 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  int      sh_v [NI], sh_p [NI], sh_f [NI];
  int      ac_v [NI], ac_p [NI], ac_f [NI];
  bit [NI-1:0] m_in;
  bit [NL-1:0] m_route, m_out;
  bit      m_err;
  int      m_n;
  int      m_fire [NL], m_kill [NL], m_len [NL];
`ifdef TRIG_ROUTER_SCALER_EN
  int      m_cnt [NL], m_hold [NL];
  bit [NL-1:0] m_prev;
  int      m_scal;

  function automatic int sat(input int x);
    return (x > SMAX) ? SMAX : x;
  endfunction
`endif

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      sh_v[k] = 0; sh_p[k] = 0; sh_f[k] = 0;
      ac_v[k] = 0; ac_p[k] = 0; ac_f[k] = 0;
    end
    for (int i = 0; i < NL; i++) begin
      m_fire[i] = -100; m_kill[i] = -1; m_len[i] = 0;
`ifdef TRIG_ROUTER_SCALER_EN
      m_cnt[i] = 0; m_hold[i] = 0;
`endif
    end
`ifdef TRIG_ROUTER_SCALER_EN
    m_prev = '0; m_scal = 0;
`endif
    m_in = '0; m_route = '0; m_out = '0; m_err = 1'b0; m_n = 0;
  endtask

  // One clock edge, using the inputs currently driven
  task automatic model_step();
    bit bad;
    int a;
    m_n++;
`ifdef TRIG_ROUTER_SCALER_EN
    begin
      bit [NL-1:0] mr;
      int e;
      mr = m_route & ~mask;
      m_scal = m_hold[sel];
      for (int i = 0; i < NL; i++) begin
        e = (mr[i] && !m_prev[i]) ? 1 : 0;
        if (latch) begin
          m_hold[i] = sat(m_cnt[i] + e);
          m_cnt[i]  = e;
        end else begin
          m_cnt[i] = sat(m_cnt[i] + e);
        end
      end
      m_prev = mr;
    end
`endif
    // output high while the latest unmasked trigger is within its stretch window
    for (int i = 0; i < NL; i++) begin
      if (mask[i]) m_kill[i] = m_n;
      else if (m_route[i]) begin
        m_fire[i] = m_n;
        m_len[i]  = int'(str);
      end
      m_out[i] = (m_fire[i] > m_kill[i]) && ((m_n - m_fire[i]) <= m_len[i]);
    end
    m_route = '0;
    for (int k = 0; k < NI; k++)
      if (ac_v[k] != 0 && ac_f[k] < NP && m_in[k]) m_route[ac_p[k] * NP + ac_f[k]] = 1'b1;
    m_in = l1;
    a   = int'(mbus.map_addr);
    bad = mbus.map_wr && (a >= NI);
    if (mbus.map_wr && !bad) begin
      sh_v[a] = int'(mbus.map_data[MAP_VALID]);
      sh_p[a] = int'(mbus.map_data[MAP_POL]);
      sh_f[a] = int'(mbus.map_data[PHI_W-1:0]);
    end
    if (bad) m_err = 1'b1;
    else if (mbus.map_commit) m_err = 1'b0;
    if (mbus.map_commit) begin
      ac_v = sh_v; ac_p = sh_p; ac_f = sh_f;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("v_model", {16'h0, vout}, {16'h0, m_out[NP-1:0]});
    chk("h_model", {16'h0, hout}, {16'h0, m_out[NL-1:NP]});
    chk("err_model", {31'h0, mbus.map_err}, {31'h0, m_err});
`ifdef TRIG_ROUTER_SCALER_EN
    chk("scaler_model", {28'h0, scal}, m_scal);
`endif
  endtask

  task automatic idle_bus();
    mbus.map_wr = 1'b0; mbus.map_addr = '0; mbus.map_data = '0; mbus.map_commit = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [NI-1:0] l1;
    logic [NL-1:0] mask;
    logic [2:0]    str;
    logic          wr;
    logic [5:0]    addr;
    logic [5:0]    data;
    logic          commit;
    logic [NP-1:0] ev;
    logic [NP-1:0] eh;
    logic          eerr;
  } vec_t;

  localparam int NV = 44;
  vec_t tv [NV];

  initial begin
    logic [NI-1:0] one;
    one = {{(NI-1){1'b0}}, 1'b1};
    for (int i = 0; i < NV; i++) tv[i] = '{default: 0};
    for (int i = 0; i < 4; i++) tv[i].l1 = {NI{1'b1}};
    tv[4].wr = 1'b1; tv[4].addr = 6'd8; tv[4].data = 6'b10_0101; tv[4].commit = 1'b1;
    tv[5].l1 = one << 8;
    tv[7].ev = 16'h0020;
    tv[9].wr = 1'b1;  tv[9].addr = 6'd0;   tv[9].data = 6'b11_1111;
    tv[10].wr = 1'b1; tv[10].addr = 6'd47; tv[10].data = 6'b11_1111; tv[10].commit = 1'b1;
    tv[11].l1 = one;
    tv[13].eh = 16'h8000;
    tv[14].l1 = one << 47;
    tv[16].eh = 16'h8000;
    for (int i = 18; i < 32; i++) tv[i].str = 3'd3;
    tv[18].l1 = one << 8;
    tv[20].l1 = one << 8;
    for (int i = 20; i <= 25; i++) tv[i].ev = 16'h0020;
    tv[27].l1 = one << 8;
    tv[29].ev = 16'h0020;
    tv[30].mask = 32'h0000_0020;
    tv[32].wr = 1'b1; tv[32].addr = 6'd4; tv[32].data = 6'b10_0010; tv[32].commit = 1'b1;
    tv[32].l1 = one << 4;
    tv[34].ev = 16'h0004;
    tv[36].wr = 1'b1; tv[36].addr = 6'd48; tv[36].data = 6'b11_1111; tv[36].eerr = 1'b1;
    tv[37].commit = 1'b1;
    tv[38].l1 = one;
    tv[40].eh = 16'h8000;
    tv[41].wr = 1'b1; tv[41].addr = 6'd50; tv[41].commit = 1'b1; tv[41].eerr = 1'b1;
    tv[42].eerr = 1'b1;
    tv[43].commit = 1'b1;

    // reset state
    idle_bus();
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_v", {16'h0, vout}, 32'h0);
    chk("reset_h", {16'h0, hout}, 32'h0);
    chk("reset_err", {31'h0, mbus.map_err}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      l1 = tv[i].l1; mask = tv[i].mask; str = tv[i].str;
      mbus.map_wr = tv[i].wr; mbus.map_addr = tv[i].addr;
      mbus.map_data = tv[i].data; mbus.map_commit = tv[i].commit;
      cycle();
      chk($sformatf("tv%0d_v", i), {16'h0, vout}, {16'h0, tv[i].ev});
      chk($sformatf("tv%0d_h", i), {16'h0, hout}, {16'h0, tv[i].eh});
      chk($sformatf("tv%0d_err", i), {31'h0, mbus.map_err}, {31'h0, tv[i].eerr});
    end

    // randomized run against the model
    for (int c = 0; c < 800; c++) begin
      if (c % 200 == 0) str = 3'($urandom_range(0, 7));
      l1 = '0;
      for (int k = 0; k < NI; k++) if ($urandom_range(0, 7) == 0) l1[k] = 1'b1;
      mask = '0;
      if ($urandom_range(0, 9) == 0) mask[$urandom_range(0, NL - 1)] = 1'b1;
      mbus.map_wr     = ($urandom_range(0, 3) == 0);
      mbus.map_addr   = 6'($urandom_range(0, 55));
      mbus.map_data   = 6'($urandom);
      mbus.map_commit = ($urandom_range(0, 15) == 0);
`ifdef TRIG_ROUTER_SCALER_EN
      latch = ($urandom_range(0, 19) == 0);
      sel   = 5'($urandom_range(0, NL - 1));
`endif
      cycle();
    end

    // asynchronous reset mid-operation clears everything, map included
    idle_bus();
    l1 = {NI{1'b1}}; mask = '0;
`ifdef TRIG_ROUTER_SCALER_EN
    latch = 1'b0; sel = 5'd3;
`endif
    rst_n = 1'b0;
    #1;
    chk("midrst_v", {16'h0, vout}, 32'h0);
    chk("midrst_h", {16'h0, hout}, 32'h0);
    chk("midrst_err", {31'h0, mbus.map_err}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      cycle();
      chk("post_rst_v", {16'h0, vout}, 32'h0);
      chk("post_rst_h", {16'h0, hout}, 32'h0);
    end
    l1 = '0;

`ifdef TRIG_ROUTER_SCALER_EN
    // scaler count, latch/readback latency and saturation
    str = 3'd0;
    mbus.map_wr = 1'b1; mbus.map_addr = 6'd8; mbus.map_data = 6'b10_0011; mbus.map_commit = 1'b1;
    cycle();
    idle_bus();
    repeat (5) begin
      l1 = {{(NI-1){1'b0}}, 1'b1} << 8;
      cycle();
      l1 = '0;
      cycle();
      cycle();
    end
    repeat (3) cycle();
    latch = 1'b1;
    cycle();
    latch = 1'b0;
    cycle();
    chk("scaler_5", {28'h0, scal}, 32'd5);
    repeat (20) begin
      l1 = {{(NI-1){1'b0}}, 1'b1} << 8;
      cycle();
      l1 = '0;
      cycle();
      cycle();
    end
    repeat (3) cycle();
    latch = 1'b1;
    cycle();
    latch = 1'b0;
    cycle();
    chk("scaler_sat", {28'h0, scal}, 32'd15);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
